cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Read-only, set-associative cache controller: tag lookup against an external line store,
// single-outstanding word refill from backing memory, round-robin replacement and invalidate-all flush.
module cache_ctrl #(
    parameter int WAY_COUNT      = 2,
    parameter int SET_COUNT      = 64,
    parameter int WAY_WORD_COUNT = 4,
    localparam int WI  = $clog2(WAY_WORD_COUNT),
    localparam int SI  = $clog2(SET_COUNT),
    localparam int TI  = 30 - WI - SI,
    localparam int WYI = $clog2(WAY_COUNT),
    localparam int LW  = 32 * WAY_WORD_COUNT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req_i,
    input  logic [31:0]             cpu_addr_i,
    output logic                    cpu_gnt_o,
    output logic                    cpu_rvalid_o,
    output logic [31:0]             cpu_rdata_o,
    input  logic                    flush_i,
    output logic                    flush_busy_o,
    output logic                    mem_req_o,
    output logic [31:0]             mem_addr_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [31:0]             mem_rdata_i,
    output logic [SI-1:0]           cm_set_o,
    output logic [WYI-1:0]          cm_way_o,
    output logic                    cm_enable_o,
    output logic                    cm_we_o,
    output logic                    cm_val_we_o,
    output logic                    cm_valid_o,
    output logic [TI-1:0]           cm_tag_o,
    output logic [LW-1:0]           cm_line_o,
    output logic [4*WAY_WORD_COUNT-1:0] cm_be_o,
    input  logic [WAY_COUNT-1:0]    cm_valid_i,
    input  logic [TI*WAY_COUNT-1:0] cm_tag_i,
    input  logic [LW-1:0]           cm_line_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_DATA,
        S_REFILL,
        S_WRITE,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:2]      r_addr;
    logic             r_pending_flush;
    logic [WI-1:0]    r_word;
    logic             r_wait;
    logic [LW-1:0]    r_buf;
    logic [WYI-1:0]   r_hit_way;
    logic [WYI-1:0]   r_victim;
    logic [WYI-1:0]   r_rr;
    logic [SI+WYI-1:0] r_flush_idx;

    logic             w_hit;
    logic [WYI-1:0]   w_hit_way;
    logic             w_free;
    logic [WYI-1:0]   w_free_way;
    logic [WYI-1:0]   w_victim;
    logic [SI-1:0]    w_req_set;
    logic [SI-1:0]    w_set;
    logic [TI-1:0]    w_tag;
    logic [WI-1:0]    w_word_sel;
    logic             w_unused;

    assign w_req_set  = cpu_addr_i[2+WI +: SI];
    assign w_set      = r_addr[2+WI +: SI];
    assign w_tag      = r_addr[31 -: TI];
    assign w_word_sel = r_addr[2 +: WI];
    assign w_unused   = ^cpu_addr_i[1:0];

    // Loops run from the highest way down so the lowest matching way is the last one assigned.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_free     = 1'b0;
        w_free_way = '0;
        for (int w = WAY_COUNT - 1; w >= 0; w--) begin
            if (cm_valid_i[w] && (cm_tag_i[w*TI +: TI] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WYI'(w);
            end
            if (!cm_valid_i[w]) begin
                w_free     = 1'b1;
                w_free_way = WYI'(w);
            end
        end
    end

    assign w_victim = w_free ? w_free_way : r_rr;

    // NOTE: every output and the next state get a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        cpu_gnt_o    = 1'b0;
        cpu_rvalid_o = 1'b0;
        cpu_rdata_o  = '0;
        flush_busy_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        cm_set_o     = '0;
        cm_way_o     = '0;
        cm_enable_o  = 1'b0;
        cm_we_o      = 1'b0;
        cm_val_we_o  = 1'b0;
        cm_valid_o   = 1'b0;
        cm_tag_o     = '0;
        cm_line_o    = '0;
        cm_be_o      = '0;

        case (r_state)
            S_IDLE: begin
                if (r_pending_flush || flush_i) begin
                    w_state_next = S_FLUSH;
                end else if (cpu_req_i) begin
                    cpu_gnt_o    = 1'b1;
                    cm_enable_o  = 1'b1;
                    cm_set_o     = w_req_set;
                    w_state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                cm_set_o = w_set;
                if (w_hit) begin
                    cm_enable_o  = 1'b1;
                    cm_way_o     = w_hit_way;
                    w_state_next = S_DATA;
                end else begin
                    w_state_next = S_REFILL;
                end
            end
            S_DATA: begin
                cm_set_o     = w_set;
                cm_way_o     = r_hit_way;
                cpu_rvalid_o = 1'b1;
                cpu_rdata_o  = cm_line_i[{w_word_sel, 5'd0} +: 32];
                w_state_next = S_IDLE;
            end
            S_REFILL: begin
                mem_req_o  = ~r_wait;
                mem_addr_o = {r_addr[31:2+WI], r_word, 2'b00};
                if (r_wait && mem_rvalid_i && (&r_word)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                cm_enable_o  = 1'b1;
                cm_we_o      = 1'b1;
                cm_set_o     = w_set;
                cm_way_o     = r_victim;
                cm_valid_o   = 1'b1;
                cm_tag_o     = w_tag;
                cm_line_o    = r_buf;
                cm_be_o      = '1;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                cpu_rvalid_o = 1'b1;
                cpu_rdata_o  = r_buf[{w_word_sel, 5'd0} +: 32];
                w_state_next = S_IDLE;
            end
            S_FLUSH: begin
                flush_busy_o = 1'b1;
                cm_enable_o  = 1'b1;
                cm_val_we_o  = 1'b1;
                cm_set_o     = r_flush_idx[WYI +: SI];
                cm_way_o     = r_flush_idx[0 +: WYI];
                if (&r_flush_idx) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: the refill buffer is reset along with the control state, so an abandoned refill
    // never leaves stale words that a later read could observe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_pending_flush <= 1'b0;
            r_word          <= '0;
            r_wait          <= 1'b0;
            r_buf           <= '0;
            r_hit_way       <= '0;
            r_victim        <= '0;
            r_rr            <= '0;
            r_flush_idx     <= '0;
        end else begin
            r_state <= w_state_next;

            if ((r_state == S_FLUSH) && (w_state_next == S_IDLE)) begin
                r_pending_flush <= 1'b0;
            end else if (flush_i && (r_state != S_FLUSH)) begin
                r_pending_flush <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (cpu_gnt_o) begin
                        r_addr <= cpu_addr_i[31:2];
                    end
                end
                S_LOOKUP: begin
                    r_hit_way <= w_hit_way;
                    r_word    <= '0;
                    r_wait    <= 1'b0;
                    if (!w_hit) begin
                        r_victim <= w_victim;
                        // The pointer only moves when it actually chose the victim.
                        if (!w_free) begin
                            r_rr <= r_rr + 1'b1;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_req_o && mem_gnt_i) begin
                        r_wait <= 1'b1;
                    end else if (r_wait && mem_rvalid_i) begin
                        r_buf[{r_word, 5'd0} +: 32] <= mem_rdata_i;
                        r_wait <= 1'b0;
                        r_word <= r_word + 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_flush_idx <= r_flush_idx + 1'b1;
                    if (&r_flush_idx) begin
                        r_rr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: line-store model, word-at-a-time memory responder and
// hand-computed expectations for miss, hit, replacement, flush, stalled grant and mid-refill reset.
module tb_cache_ctrl;

    localparam int WAYS = 2;
    localparam int SETS = 64;
    localparam int TI   = 22;
    localparam int SI   = 6;
    localparam int WYI  = 1;
    localparam int LW   = 128;

    logic            clk;
    logic            reset;
    logic            cpu_req_i;
    logic [31:0]     cpu_addr_i;
    logic            cpu_gnt_o;
    logic            cpu_rvalid_o;
    logic [31:0]     cpu_rdata_o;
    logic            flush_i;
    logic            flush_busy_o;
    logic            mem_req_o;
    logic [31:0]     mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;
    logic [SI-1:0]   cm_set_o;
    logic [WYI-1:0]  cm_way_o;
    logic            cm_enable_o;
    logic            cm_we_o;
    logic            cm_val_we_o;
    logic            cm_valid_o;
    logic [TI-1:0]   cm_tag_o;
    logic [LW-1:0]   cm_line_o;
    logic [15:0]     cm_be_o;
    logic [WAYS-1:0] cm_valid_i;
    logic [TI*WAYS-1:0] cm_tag_i = '0;
    logic [LW-1:0]   cm_line_i = '0;

    cache_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req_i    (cpu_req_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_gnt_o    (cpu_gnt_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .flush_i      (flush_i),
        .flush_busy_o (flush_busy_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .cm_set_o     (cm_set_o),
        .cm_way_o     (cm_way_o),
        .cm_enable_o  (cm_enable_o),
        .cm_we_o      (cm_we_o),
        .cm_val_we_o  (cm_val_we_o),
        .cm_valid_o   (cm_valid_o),
        .cm_tag_o     (cm_tag_o),
        .cm_line_o    (cm_line_o),
        .cm_be_o      (cm_be_o),
        .cm_valid_i   (cm_valid_i),
        .cm_tag_i     (cm_tag_i),
        .cm_line_i    (cm_line_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line store: valid is combinational on the addressed set, tags/line register on enable.
    logic [WAYS-1:0] mdl_valid [SETS]       = '{default: '0};
    logic [TI-1:0]   mdl_tag   [SETS][WAYS] = '{default: '0};
    logic [LW-1:0]   mdl_line  [SETS][WAYS] = '{default: '0};

    assign cm_valid_i = mdl_valid[cm_set_o];

    always @(posedge clk) begin
        if (cm_enable_o) begin
            for (int w = 0; w < WAYS; w++) cm_tag_i[w*TI +: TI] <= mdl_tag[cm_set_o][w];
            cm_line_i <= mdl_line[cm_set_o][cm_way_o];
            if (cm_we_o) begin
                mdl_valid[cm_set_o][cm_way_o] <= cm_valid_o;
                mdl_tag[cm_set_o][cm_way_o]   <= cm_tag_o;
                for (int b = 0; b < 16; b++)
                    if (cm_be_o[b]) mdl_line[cm_set_o][cm_way_o][b*8 +: 8] <= cm_line_o[b*8 +: 8];
            end else if (cm_val_we_o) begin
                mdl_valid[cm_set_o][cm_way_o] <= cm_valid_o;
            end
        end
    end

    // Line-store write monitor.
    int              we_cnt = 0;
    int              val_we_cnt = 0;
    int              val_order_err = 0;
    logic [SI-1:0]   last_we_set = '0;
    logic [WYI-1:0]  last_we_way = '0;
    logic [TI-1:0]   last_we_tag = '0;
    logic [LW-1:0]   last_we_line = '0;
    logic [15:0]     last_we_be = '0;

    always @(negedge clk) begin
        if (cm_enable_o && cm_we_o) begin
            we_cnt++;
            last_we_set  = cm_set_o;
            last_we_way  = cm_way_o;
            last_we_tag  = cm_tag_o;
            last_we_line = cm_line_o;
            last_we_be   = cm_be_o;
        end
        if (cm_enable_o && cm_val_we_o) begin
            if ((int'(cm_set_o) != val_we_cnt / WAYS) || (int'(cm_way_o) != val_we_cnt % WAYS) ||
                (cm_valid_o !== 1'b0))
                val_order_err++;
            val_we_cnt++;
        end
    end

    // Backing memory: grants at the negedge a request is seen (optionally after a stall on
    // word 2), returns data one cycle later.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return ((({4'h0, a[31:4]}) ^ 32'h4) << 8) | (32'hA0 + {30'b0, a[3:2]});
    endfunction

    bit          delay_en = 1'b0;
    int          gnt_cnt = 0;
    int          stab_err = 0;
    logic [31:0] gnt_addr_q[$];

    initial begin
        bit          resp_pend = 1'b0;
        logic [31:0] resp_addr = '0;
        bit          req_seen = 1'b0;
        logic [31:0] held_addr = '0;
        int          wait_left = 0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (resp_pend) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_data(resp_addr);
                resp_pend    = 1'b0;
            end
            if (mem_req_o) begin
                if (req_seen && (mem_addr_o !== held_addr)) stab_err++;
                if (!req_seen) begin
                    req_seen  = 1'b1;
                    held_addr = mem_addr_o;
                    wait_left = (delay_en && (mem_addr_o[3:2] == 2'd2)) ? 5 : 0;
                end
                if (wait_left == 0) begin
                    mem_gnt_i = 1'b1;
                    resp_pend = 1'b1;
                    resp_addr = mem_addr_o;
                    req_seen  = 1'b0;
                    gnt_cnt++;
                    gnt_addr_q.push_back(mem_addr_o);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit outs_zero();
        return ~|{cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, flush_busy_o, mem_req_o, mem_addr_o,
                  cm_set_o, cm_way_o, cm_enable_o, cm_we_o, cm_val_we_o, cm_valid_o,
                  cm_tag_o, cm_line_o, cm_be_o};
    endfunction

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        lat = 0;
        d   = '0;
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        #1;
        n = 0;
        while (!cpu_gnt_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cpu_gnt_o) begin
            cpu_req_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cpu_req_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_rvalid_o) begin
                d  = cpu_rdata_o;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic miss_check(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                              input logic [WYI-1:0] exp_way, input logic [TI-1:0] exp_tag);
        logic [31:0] d;
        int          lat;
        bit          ok;
        int          g0;
        g0 = gnt_cnt;
        cpu_read(a, d, lat, ok);
        check({tag, "_done"}, 128'(ok), 128'(1));
        check({tag, "_data"}, 128'(d), 128'(exp_d));
        check({tag, "_way"}, 128'(last_we_way), 128'(exp_way));
        check({tag, "_set"}, 128'(last_we_set), 128'(0));
        check({tag, "_tag"}, 128'(last_we_tag), 128'(exp_tag));
        check({tag, "_grants"}, 128'(gnt_cnt - g0), 128'(4));
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        bit          ok;
        int          g0, we0, s0, n;

        reset      = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = '0;
        flush_i    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs_zero", 128'(outs_zero()), 128'(1));
        reset = 1'b0;

        // Cold miss on 0x40: four line-aligned fetches, written to set 4 way 0.
        g0 = gnt_cnt; we0 = we_cnt;
        cpu_read(32'h40, d, lat, ok);
        check("cold_done", 128'(ok), 128'(1));
        check("cold_data", 128'(d), 128'(32'hA0));
        check("cold_grants", 128'(gnt_cnt - g0), 128'(4));
        for (int k = 0; k < 4; k++)
            check($sformatf("cold_addr%0d", k), 128'(gnt_addr_q[g0 + k]), 128'(32'h40 + 4 * k));
        check("cold_we_count", 128'(we_cnt - we0), 128'(1));
        check("cold_we_set", 128'(last_we_set), 128'(4));
        check("cold_we_way", 128'(last_we_way), 128'(0));
        check("cold_we_tag", 128'(last_we_tag), 128'(0));
        check("cold_we_line", last_we_line, 128'h000000A3_000000A2_000000A1_000000A0);
        check("cold_we_be", 128'(last_we_be), 128'(16'hFFFF));

        // Hit on 0x48 from the same line.
        g0 = gnt_cnt;
        cpu_read(32'h48, d, lat, ok);
        check("hit_done", 128'(ok), 128'(1));
        check("hit_data", 128'(d), 128'(32'hA2));
        check("hit_latency", 128'(lat), 128'(2));
        check("hit_no_mem", 128'(gnt_cnt - g0), 128'(0));

        // Replacement in set 0: free way first, then round-robin.
        miss_check("repl0", 32'h000, 32'h000004A0, 1'b0, 22'd0);
        miss_check("repl1", 32'h400, 32'h000044A0, 1'b1, 22'd1);
        miss_check("repl2", 32'h800, 32'h000084A0, 1'b0, 22'd2);
        miss_check("repl3", 32'hC00, 32'h0000C4A0, 1'b1, 22'd3);

        // Flush pulse with a simultaneous request: no grant, 128 valid clears.
        @(negedge clk);
        flush_i    = 1'b1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h48;
        #1;
        check("flush_no_grant", 128'(cpu_gnt_o), 128'(0));
        @(negedge clk);
        flush_i   = 1'b0;
        cpu_req_i = 1'b0;
        n = 0;
        while (flush_busy_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("flush_busy_cycles", 128'(n), 128'(128));
        check("flush_clear_writes", 128'(val_we_cnt), 128'(128));
        check("flush_clear_order", 128'(val_order_err), 128'(0));

        // Post-flush read of 0x48 misses; word 2 grant stalled by five cycles.
        delay_en = 1'b1;
        g0 = gnt_cnt; s0 = stab_err; we0 = we_cnt;
        cpu_read(32'h48, d, lat, ok);
        delay_en = 1'b0;
        check("stall_done", 128'(ok), 128'(1));
        check("stall_data", 128'(d), 128'(32'hA2));
        check("stall_is_miss", 128'(lat > 2), 128'(1));
        check("stall_grants", 128'(gnt_cnt - g0), 128'(4));
        for (int k = 0; k < 4; k++)
            check($sformatf("stall_addr%0d", k), 128'(gnt_addr_q[g0 + k]), 128'(32'h40 + 4 * k));
        check("stall_addr_stable", 128'(stab_err - s0), 128'(0));
        check("stall_we_count", 128'(we_cnt - we0), 128'(1));
        check("stall_we_way", 128'(last_we_way), 128'(0));
        check("stall_we_line", last_we_line, 128'h000000A3_000000A2_000000A1_000000A0);

        // Reset while word 1 of a refill of 0x1040 is being requested.
        we0 = we_cnt;
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h1040;
        @(posedge clk);
        #1 cpu_req_i = 1'b0;
        n = 0;
        while (!(mem_req_o && (mem_addr_o == 32'h1044)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_word1", 128'(mem_req_o && (mem_addr_o == 32'h1044)), 128'(1));
        #1 reset = 1'b1;
        #1;
        check("rst_outputs_zero", 128'(outs_zero()), 128'(1));
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_idle_outputs_zero", 128'(outs_zero()), 128'(1));
        check("rst_no_line_write", 128'(we_cnt - we0), 128'(0));

        g0 = gnt_cnt;
        cpu_read(32'h1040, d, lat, ok);
        check("rerun_done", 128'(ok), 128'(1));
        check("rerun_data", 128'(d), 128'(32'h000100A0));
        check("rerun_grants", 128'(gnt_cnt - g0), 128'(4));
        check("rerun_first_addr", 128'(gnt_addr_q[g0]), 128'(32'h1040));
        check("rerun_we_count", 128'(we_cnt - we0), 128'(1));
        check("rerun_we_set", 128'(last_we_set), 128'(4));
        check("rerun_we_way", 128'(last_we_way), 128'(1));
        check("rerun_we_tag", 128'(last_we_tag), 128'(4));
        check("rerun_we_line", last_we_line, 128'h000100A3_000100A2_000100A1_000100A0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
